uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 89 ++++++++
 tb/tb_uart_tx_arbiter.sv | 139 +++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART transmit arbiter.
// master = requesters plus transmitter side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      ack;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;
  logic                 busy;
  logic [IDW-1:0]       grant_id;

  modport master (
    output req, req_data, tx_done_tick,
    input  ack, tx_start, tx_din, busy, grant_id
  );

  modport slave (
    input  req, req_data, tx_done_tick,
    output ack, tx_start, tx_din, busy, grant_id
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational winner selection: round-robin starting after i_pointer, or
// lowest-index fixed priority when UART_ARB_FIXED_PRIO_EN is defined.
module uart_rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_pointer,
  output logic            o_valid,
  output logic [IDW-1:0]  o_index
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic w_unused_pointer;
  assign w_unused_pointer = ^i_pointer;

  // Scanning downward lets the lowest asserted index overwrite the rest.
  always_comb begin
    o_valid = |i_req;
    o_index = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_index = IDW'(i);
    end
  end
`else
  // Search order: pointer+1, pointer+2, ... wrapping, pointer itself last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int s = 1; s <= NREQ; s++) begin
      if (!o_valid && i_req[(int'(i_pointer) + s) % NREQ]) begin
        o_valid = 1'b1;
        o_index = IDW'((int'(i_pointer) + s) % NREQ);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters (IDLE/START/WAIT/DONE).
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DBIT = 8
) (
  input  logic               clk,
  input  logic               rstn,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NREQ);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_ack;
  logic            r_tx_start;
  logic [DBIT-1:0] r_tx_din;
  logic            r_busy;
  logic [IDW-1:0]  r_grant_id;
  logic [IDW-1:0]  r_pointer;

  logic            w_valid;
  logic [IDW-1:0]  w_index;
  logic [DBIT-1:0] w_word;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req     (bus.req),
    .i_pointer (r_pointer),
    .o_valid   (w_valid),
    .o_index   (w_index)
  );

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_index == IDW'(i)) w_word = bus.req_data[i*DBIT +: DBIT];
    end
  end

  // Outputs are set on entry to the state that owns them, so they are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
      r_pointer  <= IDW'(NREQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_tx_din   <= w_word;
            r_grant_id <= w_index;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.tx_done_tick) begin
            r_ack   <= NREQ'(1) << r_grant_id;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_ack     <= '0;
          r_busy    <= 1'b0;
          r_pointer <= r_grant_id;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_din   = r_tx_din;
  assign bus.busy     = r_busy;
  assign bus.grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, fairness, wrap, stray tick,
// data hold, priority pattern and reset during a frame.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DBIT = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();
  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_err = 0;
  int n_chk = 0;
  logic [DBIT-1:0] words [NREQ] = '{8'hC3, 8'h5A, 8'hA5, 8'h3C};

`ifdef UART_ARB_FIXED_PRIO_EN
  int exp_fair [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int exp_prio [3] = '{1, 1, 1};
`else
  int exp_fair [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_prio [3] = '{3, 1, 3};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.tx_start) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic frame(input int exp_id, input bit drop, input bit mutate);
    bit seen;
    wait_start(seen);
    if (seen) begin
      chk("grant_id", 32'(bus.grant_id), 32'(exp_id));
      chk("tx_din", 32'(bus.tx_din), 32'(words[exp_id]));
      chk("busy_start", 32'(bus.busy), 32'd1);
      if (drop) bus.req = '0;
      if (mutate) bus.req_data[exp_id*DBIT +: DBIT] = ~words[exp_id];
      @(posedge clk); #1;
      chk("start_one_cycle", 32'(bus.tx_start), 32'd0);
      chk("ack_in_wait", 32'(bus.ack), 32'd0);
      @(posedge clk); #1;
      chk("tx_din_hold", 32'(bus.tx_din), 32'(words[exp_id]));
      bus.tx_done_tick = 1'b1;
      @(posedge clk); #1;
      bus.tx_done_tick = 1'b0;
      chk("ack", 32'(bus.ack), 32'd1 << exp_id);
      chk("busy_done", 32'(bus.busy), 32'd1);
      chk("grant_id_done", 32'(bus.grant_id), 32'(exp_id));
      if (mutate) bus.req_data[exp_id*DBIT +: DBIT] = words[exp_id];
      @(posedge clk); #1;
      chk("ack_one_cycle", 32'(bus.ack), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    bit seen;
    rstn             = 1'b0;
    bus.req          = '0;
    bus.tx_done_tick = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DBIT +: DBIT] = words[i];

    #12;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_din", 32'(bus.tx_din), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) frame(exp_fair[i], 1'b0, 1'b0);

    bus.req = 4'b1001;
    frame(0, 1'b1, 1'b0);

    bus.tx_done_tick = 1'b1;
    @(posedge clk); #1;
    bus.tx_done_tick = 1'b0;
    chk("stray_ack", 32'(bus.ack), 32'd0);
    chk("stray_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("stray_ack2", 32'(bus.ack), 32'd0);
    chk("stray_start", 32'(bus.tx_start), 32'd0);

    bus.req = 4'b0100;
    frame(2, 1'b1, 1'b1);

    bus.req = 4'b1010;
    for (int i = 0; i < 3; i++) frame(exp_prio[i], i == 2, 1'b0);

    bus.req = 4'b0100;
    wait_start(seen);
    chk("pre_rst_grant", 32'(bus.grant_id), 32'd2);
    @(posedge clk); #1;
    bus.req = 4'b0110;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mid_rst_tx_din", 32'(bus.tx_din), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
    bus.tx_done_tick = 1'b1;
    @(posedge clk); #1;
    bus.tx_done_tick = 1'b0;
    chk("mid_rst_no_ack", 32'(bus.ack), 32'd0);
    @(negedge clk) rstn = 1'b1;
    frame(1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
